// File: rtl/present_sbox_sched_if.sv
// present_sbox_sched_if: valid/ready handshake bundle for present_sbox_sched.
// Build option: PRESENT_SBOX_INV_EN adds the 'inv' select line,
// which travels with in_data.
interface present_sbox_sched_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
`ifdef PRESENT_SBOX_INV_EN
    logic        inv;

    modport master (
        output in_valid, in_data, inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, inv, out_ready,
        output in_ready, out_valid, out_data
    );
`else
    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
`endif
endinterface

// File: rtl/present_sbox_sched.sv
// present_sbox_sched: applies the PRESENT-80 4-bit S-box to a 64-bit state
// using NUM_SBOX shared lanes over 16/NUM_SBOX RUN cycles.
// Nibble 0 is processed first.
// Build option: PRESENT_SBOX_INV_EN adds a per-operation inverse S-box select.
// Reset is synchronous and active-high.
module present_sbox_sched #(
    parameter int NUM_SBOX = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    present_sbox_sched_if.slave  bus,
    output logic                 busy
);

    localparam int          STEPS      = 16 / NUM_SBOX;
    localparam int          SLICE_W    = 4 * NUM_SBOX;
    localparam logic [3:0]  LAST_CNT   = 4'(STEPS - 1);
    localparam logic [63:0] SLICE_MASK = {64{1'b1}} >> (64 - SLICE_W);

    generate
        if (NUM_SBOX != 1 && NUM_SBOX != 2 && NUM_SBOX != 4 &&
            NUM_SBOX != 8 && NUM_SBOX != 16) begin : g_bad_num_sbox
            $error("present_sbox_sched: NUM_SBOX must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [3:0]          cnt_q;
    logic [63:0]         data_q;
    logic [63:0]         data_d;
    logic [5:0]          shamt;
    logic [SLICE_W-1:0]  slice_in;
    logic [SLICE_W-1:0]  slice_out;
`ifdef PRESENT_SBOX_INV_EN
    logic                inv_q;
`endif

    function automatic logic [3:0] sbox_fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

`ifdef PRESENT_SBOX_INV_EN
    function automatic logic [3:0] sbox_inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction
`endif

    // The current slice starts at nibble cnt*NUM_SBOX.
    // The product is at most 60 for every legal NUM_SBOX.
    assign shamt    = 6'(int'(cnt_q) * SLICE_W);
    assign slice_in = SLICE_W'(data_q >> shamt);

    // S-box lanes: lane k substitutes nibble k of the current slice.
    always_comb begin
        // NOTE: every variable written in a combinational block gets a default
        // first, so no path through the block can leave it unassigned and
        // infer a latch.
        slice_out = '0;
        for (int k = 0; k < NUM_SBOX; k++) begin
`ifdef PRESENT_SBOX_INV_EN
            slice_out[4*k +: 4] = inv_q ? sbox_inv(slice_in[4*k +: 4])
                                        : sbox_fwd(slice_in[4*k +: 4]);
`else
            slice_out[4*k +: 4] = sbox_fwd(slice_in[4*k +: 4]);
`endif
        end
    end

    // Merge the substituted slice back into the state, leaving other nibbles intact.
    assign data_d = (data_q & ~(SLICE_MASK << shamt)) | (64'(slice_out) << shamt);

    // FSM state register; rst takes priority over every handshake.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with non-blocking <= so every
        // register samples pre-edge values, independent of statement order.
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (bus.in_valid)       state_d = RUN;
            RUN:  if (cnt_q == LAST_CNT)  state_d = DONE;
            DONE: if (bus.out_ready)      state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // FSM outputs: handshake flags and busy are decoded from the state alone.
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        case (state_q)
            IDLE: bus.in_ready = 1'b1;
            RUN:  busy         = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath: capture on accept, substitute one slice per RUN cycle, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: data_q is a plain register rather than a memory array.
            // Its value shows on out_data, so it is reset along with the control state.
            data_q <= '0;
            cnt_q  <= '0;
`ifdef PRESENT_SBOX_INV_EN
            inv_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        data_q <= bus.in_data;
                        cnt_q  <= '0;
`ifdef PRESENT_SBOX_INV_EN
                        inv_q  <= bus.inv;
`endif
                    end
                end
                RUN: begin
                    data_q <= data_d;
                    cnt_q  <= (cnt_q == LAST_CNT) ? 4'd0 : cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // The result register is visible in every state and holds the last result in IDLE.
    assign bus.out_data = data_q;

endmodule

// File: tb/tb_present_sbox_sched.sv
// tb_present_sbox_sched: scoreboard bench for present_sbox_sched.
// It instantiates three DUTs with NUM_SBOX = 1, 4 and 16.
// Stimulus pushes expected results into per-DUT queues.
// Monitors pop and compare them on each output handshake.
// Expected results are derived nibble by nibble from the S-box table.
module tb_present_sbox_sched;

    logic clk = 1'b0;
    logic rst;
    logic busy1, busy4, busy16;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lat;

    logic [63:0] q1[$];
    logic [63:0] q4[$];
    logic [63:0] q16[$];
    logic [63:0] vec_in  [4];
    logic [63:0] vec_exp [4];
    logic [63:0] held;

    always #5 clk = ~clk;

    present_sbox_sched_if b1 ();
    present_sbox_sched_if b4 ();
    present_sbox_sched_if b16 ();

    present_sbox_sched #(.NUM_SBOX(1))  dut1  (.clk(clk), .rst(rst), .bus(b1),  .busy(busy1));
    present_sbox_sched #(.NUM_SBOX(4))  dut4  (.clk(clk), .rst(rst), .bus(b4),  .busy(busy4));
    present_sbox_sched #(.NUM_SBOX(16)) dut16 (.clk(clk), .rst(rst), .bus(b16), .busy(busy16));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: one per DUT; each compares the presented result on every out handshake.
    always @(negedge clk) begin
        if (!rst && b1.out_valid && b1.out_ready) begin
            if (q1.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut1 unexpected output: got %h expected none", b1.out_data);
            end else check("dut1 result", b1.out_data, q1.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && b4.out_valid && b4.out_ready) begin
            if (q4.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut4 unexpected output: got %h expected none", b4.out_data);
            end else check("dut4 result", b4.out_data, q4.pop_front());
        end
    end

    always @(negedge clk) begin
        if (!rst && b16.out_valid && b16.out_ready) begin
            if (q16.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL dut16 unexpected output: got %h expected none", b16.out_data);
            end else check("dut16 result", b16.out_data, q16.pop_front());
        end
    end

    // Drive one state into dut1.
    // The task returns one step after the accepting edge, with in_valid low.
    task automatic load1(input logic [63:0] d);
        check("dut1 in_ready before load", 64'(b1.in_ready), 64'd1);
        b1.in_valid = 1'b1;
        b1.in_data  = d;
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
    endtask

    // Count edges until dut1 raises out_valid, bounded.
    task automatic wait_valid1(output int edges);
        edges = 0;
        while (!b1.out_valid && edges < 100) begin
            @(posedge clk); #1;
            edges++;
        end
        if (!b1.out_valid) begin
            n_tests++; n_fail++;
            $display("FAIL dut1 out_valid timeout: got 0 expected 1");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b1.in_valid  = 1'b0; b1.in_data  = '0; b1.out_ready  = 1'b0;
        b4.in_valid  = 1'b0; b4.in_data  = '0; b4.out_ready  = 1'b0;
        b16.in_valid = 1'b0; b16.in_data = '0; b16.out_ready = 1'b0;
`ifdef PRESENT_SBOX_INV_EN
        b1.inv = 1'b0; b4.inv = 1'b0; b16.inv = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset in_ready",  64'(b1.in_ready),  64'd1);
        check("reset out_valid", 64'(b1.out_valid), 64'd0);
        check("reset busy",      64'(busy1),        64'd0);
        check("reset out_data",  b1.out_data,       64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // All-zero state: every nibble maps 0 -> C; the latency is 16 edges.
        b1.out_ready = 1'b1;
        q1.push_back(64'hCCCC_CCCC_CCCC_CCCC);
        load1(64'h0);
        check("dut1 busy in RUN", 64'(busy1), 64'd1);
        wait_valid1(lat);
        check("dut1 latency", 64'(lat), 64'd16);
        @(posedge clk); #1;
        check("dut1 idle in_ready",  64'(b1.in_ready),  64'd1);
        check("dut1 idle out_valid", 64'(b1.out_valid), 64'd0);
        check("dut1 idle busy",      64'(busy1),        64'd0);
        check("dut1 idle holds result", b1.out_data, 64'hCCCC_CCCC_CCCC_CCCC);

        // Four lanes with a distinct nibble in each position; the latency is 4 edges.
        b4.out_ready = 1'b1;
        check("dut4 in_ready", 64'(b4.in_ready), 64'd1);
        b4.in_valid = 1'b1;
        b4.in_data  = 64'hFEDC_BA98_7654_3210;
        q4.push_back(64'h2174_8FE3_DA09_B65C);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("dut4 latency", 64'(lat), 64'd4);
        @(posedge clk); #1;

        // Back-pressure: a stray in_valid during RUN and DONE must not be captured.
        b1.out_ready = 1'b0;
        q1.push_back(64'hC56B_90AD_3EF8_4712);
        load1(64'h0123_4567_89AB_CDEF);
        @(posedge clk); #1;
        b1.in_valid = 1'b1;
        b1.in_data  = 64'hDEAD_BEEF_0000_1111;
        check("dut1 in_ready low in RUN", 64'(b1.in_ready), 64'd0);
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        wait_valid1(lat);
        held = b1.out_data;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) b1.in_valid = 1'b1;
            @(posedge clk); #1;
            check("dut1 out_valid held",   64'(b1.out_valid), 64'd1);
            check("dut1 out_data stable",  b1.out_data,       held);
            check("dut1 in_ready low in DONE", 64'(b1.in_ready), 64'd0);
        end
        b1.in_valid  = 1'b0;
        b1.out_ready = 1'b1;
        @(posedge clk); #1;
        check("dut1 back to IDLE", 64'(b1.in_ready), 64'd1);

        // Reset in the fifth RUN cycle aborts the operation without any output.
        load1(64'h1111_2222_3333_4444);
        repeat (4) begin @(posedge clk); #1; end
        check("dut1 busy before abort", 64'(busy1), 64'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("abort in_ready",  64'(b1.in_ready),  64'd1);
        check("abort out_valid", 64'(b1.out_valid), 64'd0);
        check("abort busy",      64'(busy1),        64'd0);
        check("abort out_data",  b1.out_data,       64'd0);
        repeat (20) begin @(posedge clk); #1; end
        check("abort no late out_valid", 64'(b1.out_valid), 64'd0);
        q1.push_back(64'h2222_2222_2222_2222);
        load1(64'hFFFF_FFFF_FFFF_FFFF);
        wait_valid1(lat);
        check("dut1 latency after abort", 64'(lat), 64'd16);
        @(posedge clk); #1;

        // Sixteen lanes with in_valid held high produce one result every three cycles.
        vec_in  = '{64'h0, 64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
        vec_exp = '{64'hCCCC_CCCC_CCCC_CCCC, 64'h2174_8FE3_DA09_B65C,
                    64'hC56B_90AD_3EF8_4712, 64'h2222_2222_2222_2222};
        b16.out_ready = 1'b1;
        b16.in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b16.in_data = vec_in[i];
            q16.push_back(vec_exp[i]);
            check("dut16 in_ready before accept", 64'(b16.in_ready), 64'd1);
            @(posedge clk); #1;
            check("dut16 busy in RUN", 64'(busy16), 64'd1);
            @(posedge clk); #1;
            check("dut16 out_valid after 1 edge", 64'(b16.out_valid), 64'd1);
            @(posedge clk); #1;
            check("dut16 DONE lasts one cycle", 64'(b16.out_valid), 64'd0);
        end
        b16.in_valid = 1'b0;

`ifdef PRESENT_SBOX_INV_EN
        // Forward then inverse must round-trip; inv is flipped after accept to show it is held.
        b4.inv      = 1'b0;
        b4.in_valid = 1'b1;
        b4.in_data  = 64'hFEDC_BA98_7654_3210;
        q4.push_back(64'h2174_8FE3_DA09_B65C);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b4.inv      = 1'b1;
        lat = 0;
        while (!b4.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("dut4 fwd latency", 64'(lat), 64'd4);
        @(posedge clk); #1;
        b4.inv      = 1'b1;
        b4.in_valid = 1'b1;
        b4.in_data  = 64'h2174_8FE3_DA09_B65C;
        q4.push_back(64'hFEDC_BA98_7654_3210);
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
        b4.inv      = 1'b0;
        lat = 0;
        while (!b4.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        check("dut4 inv latency", 64'(lat), 64'd4);
        @(posedge clk); #1;
`endif

        repeat (5) @(posedge clk);
        #1;
        check("dut1 scoreboard drained",  64'(q1.size()),  64'd0);
        check("dut4 scoreboard drained",  64'(q4.size()),  64'd0);
        check("dut16 scoreboard drained", 64'(q16.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
